ram_access_ctrl: RTL and testbench
==================================

// Module: ram_access_ctrl
// PURPOSE
// - Arbitrates the single-port zero-delay data RAM between the RV32I fetch port (read-only) and load/store port.
// - Sequences byte/half stores as read-modify-write; sign/zero-extends loads.
// - Swaps RAM lane order to little-endian; flags misaligned/out-of-range accesses.
// - Sits between the core and the RAM; the RAM is never driven directly by the core.
// PARAMETERS
// - RAM_ADDR_SIZE  16  RAM byte-address width; any byte addr >= 2**RAM_ADDR_SIZE is out of range.
// - MAX_STALL      4   consecutive data grants tolerated while fetch waits (ARB_FAIRNESS_EN only).
// PORTS
// - clock             in   1   system clock, rising edge.
// - reset             in   1   synchronous, active-high.
// - if_req            in   1   fetch request; held until if_gnt.
// - if_addr           in   32  fetch byte address.
// - if_gnt            out  1   fetch request accepted this cycle.
// - if_valid          out  1   one-cycle fetch response pulse.
// - if_rdata          out  32  fetched word, little-endian.
// - if_err            out  1   with if_valid: misaligned or out of range.
// - dm_req            in   1   load/store request; held until dm_gnt.
// - dm_we             in   1   1 = store, 0 = load.
// - dm_addr           in   32  data byte address.
// - dm_size           in   2   00 byte, 01 half, 10 word, 11 illegal.
// - dm_unsigned       in   1   load zero-extend (LBU/LHU); ignored on stores.
// - dm_wdata          in   32  store data, right-justified.
// - dm_gnt            out  1   data request accepted this cycle.
// - dm_valid          out  1   one-cycle data response pulse (loads and stores).
// - dm_rdata          out  32  extended load data; 0 for stores/errors.
// - dm_err            out  1   with dm_valid: misaligned, out of range, or size 11.
// - ram_addr          out  32  RAM address = {base[31:2],2'b11}.
// - ram_data_in       out  32  RAM write word, RAM lane order.
// - ram_write_control out  1   RAM write strobe.
// - ram_data_out      in   32  RAM read word: [31:24]=mem[base] ... [7:0]=mem[base+3].
// BEHAVIOUR
// - Clock/reset: one clock; reset is synchronous and active-high. All outputs are 0 after reset; state = IDLE.
// - Reset overrides: ram_write_control is forced 0 in any cycle with reset=1, including mid-RMW.
// - States: IDLE, ACCESS, RMW_WR. Grants are issued only in IDLE; one access is outstanding at a time.
// - Grant and capture: gnt is combinational in IDLE cycle N. addr/size/we/wdata/unsigned are latched at end of N; next state is ACCESS.
// - Arbitration: fixed priority, data > fetch. Never both gnts in one cycle.
// - Error check: done at grant.
//   - Fetch: addr[1:0]!=0.
//   - Data: word with addr[1:0]!=0, half with addr[0]=1, or size 11.
//   - Both ports: addr >= 2**RAM_ADDR_SIZE.
//   - Errored access: no RAM write; valid+err at N+2, rdata=0; then IDLE.
// - Lane swap: LE byte k of word = RAM lane [31-8k -: 8]. Applied on both read and write paths.
// - ACCESS, load or fetch (cycle N+1): drive ram_addr, capture the swapped word.
//   - Load result = selected byte/half from addr[1:0], sign- or zero-extended.
//   - valid at N+2; then IDLE.
// - ACCESS, word store (cycle N+1): ram_write_control=1 with swapped wdata; dm_valid at N+2; then IDLE.
// - ACCESS, byte/half store (cycle N+1): read and latch the word; next state is RMW_WR.
// - RMW_WR (cycle N+2): write the word with only the addressed byte/half replaced; dm_valid at N+3; then IDLE.
// - Throughput: max 1 access / 2 cycles; sub-word stores take 1 access / 3 cycles.
// - req dropped after gnt has no effect. req never granted while not IDLE.
// CONFIGURATION
// - ARB_FAIRNESS_EN defined: 3-bit stall counter.
//   - Increments on each dm_gnt while if_req=1; clears on if_gnt, or when if_req=0.
//   - When counter == MAX_STALL, fetch wins the next IDLE arbitration.
// - ARB_FAIRNESS_EN undefined: pure data>fetch priority; fetch may starve.
// TESTING
// - Word load, LE: mem[0x100..0x103]=11,22,33,44 (hex); dm LW 0x100.
//   - Expect ram_addr=0x103 and dm_rdata=0x44332211 at N+2.
// - Byte load, signed/unsigned: same mem; LB 0x103 -> 0x00000044; set mem[0x101]=0x80.
//   - LB 0x101 -> 0xFFFFFF80; LBU 0x101 -> 0x00000080.
// - Half store RMW: word 0x44332211 at 0x100; SH 0x102 wdata=0xBEEF.
//   - Expect exactly one write at N+2; LW 0x100 then reads 0xBEEF2211.
// - Error cases: LW 0x101 -> dm_err=1, rdata=0, no write.
//   - Fetch 0x00010000 with RAM_ADDR_SIZE=16 -> if_err=1.
//   - size=11 -> dm_err=1.
// - Arbitration: if_req and dm_req both held high.
//   - Undefined ARB_FAIRNESS_EN: only dm_gnt for 10 accesses.
//   - With ARB_FAIRNESS_EN (MAX_STALL=4): if_gnt after 4th dm_gnt.
// - Reset mid-RMW: assert reset in RMW_WR cycle.
//   - Expect ram_write_control=0, RAM unchanged, all outputs 0 next cycle, IDLE.

Source files
------------

// File: rtl/ram_access_ctrl_if.sv
// ram_access_ctrl_if: fetch, load/store and RAM signal bundle for ram_access_ctrl.
// master = core plus RAM side (drives requests and ram_data_out).
// slave  = controller (drives grants, responses and the RAM address/data/strobe).
interface ram_access_ctrl_if;
  logic        if_req, if_gnt, if_valid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_unsigned, dm_gnt, dm_valid, dm_err;
  logic [1:0]  dm_size;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [31:0] ram_addr, ram_data_in, ram_data_out;
  logic        ram_write_control;
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_size, dm_unsigned, dm_wdata, ram_data_out,
    input  if_gnt, if_valid, if_rdata, if_err, dm_gnt, dm_valid, dm_rdata, dm_err,
           ram_addr, ram_data_in, ram_write_control
  );
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_size, dm_unsigned, dm_wdata, ram_data_out,
    output if_gnt, if_valid, if_rdata, if_err, dm_gnt, dm_valid, dm_rdata, dm_err,
           ram_addr, ram_data_in, ram_write_control
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: arbitrates a zero-delay single-port RAM between fetch and load/store ports.
// Ports: clock, reset (sync, active-high); bus (ram_access_ctrl_if.slave) carrying the fetch
// request/response, the load/store request/response and the RAM address/data/write strobe.
// Optional ARB_FAIRNESS_EN: after MAX_STALL back-to-back data grants with fetch waiting,
// fetch wins the next arbitration.
module ram_access_ctrl #(
  parameter int RAM_ADDR_SIZE = 16
`ifdef ARB_FAIRNESS_EN
  , parameter int MAX_STALL = 4
`endif
) (
  input logic clock,
  input logic reset,
  ram_access_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR} state_t;
  state_t r_state, w_next;
  logic r_fetch, r_we, r_unsigned, r_err;
  logic [1:0] r_size;
  logic [31:0] r_addr, r_wdata, r_word;
  logic r_if_valid, r_if_err, r_dm_valid, r_dm_err;
  logic [31:0] r_if_rdata, r_dm_rdata;
  logic w_idle, w_fetch_pri, w_if_gnt, w_dm_gnt, w_if_bad, w_dm_bad, w_rmw, w_wr;
  logic [7:0] w_byte;
  logic [15:0] w_half;
  logic [31:0] w_rd_le, w_load, w_mask, w_merged;
  // RAM lane order is big-endian; the same swap converts both directions.
  function automatic logic [31:0] swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction
  function automatic logic oor(input logic [31:0] a);
    return (a >> RAM_ADDR_SIZE) != 32'd0;
  endfunction
  assign w_idle = r_state == IDLE && !reset;
`ifdef ARB_FAIRNESS_EN
  logic [2:0] r_stall;
  assign w_fetch_pri = r_stall == 3'(MAX_STALL);
  always_ff @(posedge clock)
    r_stall <= (reset || w_if_gnt || !bus.if_req) ? 3'd0 : w_dm_gnt ? r_stall + 3'd1 : r_stall;
`else
  assign w_fetch_pri = 1'b0;
`endif
  assign w_if_gnt = w_idle && bus.if_req && (!bus.dm_req || w_fetch_pri);
  assign w_dm_gnt = w_idle && bus.dm_req && !w_if_gnt;
  assign w_if_bad = bus.if_addr[1:0] != 2'b00 || oor(bus.if_addr);
  assign w_dm_bad = bus.dm_size == 2'b11 || (bus.dm_size == 2'b10 && bus.dm_addr[1:0] != 2'b00) ||
                    (bus.dm_size == 2'b01 && bus.dm_addr[0]) || oor(bus.dm_addr);
  // Fetches are captured as size 10, so only error-free byte/half stores take the RMW path.
  assign w_rmw = !r_fetch && r_we && !r_err && r_size != 2'b10;
  assign w_rd_le = swap(bus.ram_data_out);
  assign w_byte = w_rd_le[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = r_addr[1] ? w_rd_le[31:16] : w_rd_le[15:0];
  assign w_load = r_size == 2'b00 ? {{24{!r_unsigned && w_byte[7]}}, w_byte} :
                  r_size == 2'b01 ? {{16{!r_unsigned && w_half[15]}}, w_half} : w_rd_le;
  assign w_mask = (r_size == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << {r_addr[1:0], 3'b000};
  assign w_merged = (r_word & ~w_mask) | ((r_wdata << {r_addr[1:0], 3'b000}) & w_mask);
  assign w_wr = !reset && !r_fetch && r_we && !r_err &&
                ((r_state == ACCESS && r_size == 2'b10) || r_state == RMW_WR);
  always_ff @(posedge clock)
    r_state <= reset ? IDLE : w_next;
  always_comb
    w_next = r_state == IDLE ? ((w_if_gnt || w_dm_gnt) ? ACCESS : IDLE) :
             (r_state == ACCESS && w_rmw) ? RMW_WR : IDLE;
  always_comb begin
    bus.if_gnt = w_if_gnt;
    bus.dm_gnt = w_dm_gnt;
    bus.if_valid = r_if_valid;
    bus.if_rdata = r_if_rdata;
    bus.if_err = r_if_err;
    bus.dm_valid = r_dm_valid;
    bus.dm_rdata = r_dm_rdata;
    bus.dm_err = r_dm_err;
    bus.ram_addr = (!reset && r_state != IDLE && !r_err) ? {r_addr[31:2], 2'b11} : 32'd0;
    bus.ram_write_control = w_wr;
    bus.ram_data_in = w_wr ? swap(r_state == RMW_WR ? w_merged : r_wdata) : 32'd0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch <= 1'b0;
      r_we <= 1'b0;
      r_unsigned <= 1'b0;
      r_err <= 1'b0;
      r_size <= 2'b00;
      r_addr <= 32'd0;
      r_wdata <= 32'd0;
    end else if (w_if_gnt || w_dm_gnt) begin
      r_fetch <= w_if_gnt;
      r_we <= w_dm_gnt && bus.dm_we;
      r_unsigned <= bus.dm_unsigned;
      r_err <= w_if_gnt ? w_if_bad : w_dm_bad;
      r_size <= w_if_gnt ? 2'b10 : bus.dm_size;
      r_addr <= w_if_gnt ? bus.if_addr : bus.dm_addr;
      r_wdata <= bus.dm_wdata;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_if_valid <= 1'b0;
      r_if_err <= 1'b0;
      r_if_rdata <= 32'd0;
      r_dm_valid <= 1'b0;
      r_dm_err <= 1'b0;
      r_dm_rdata <= 32'd0;
      r_word <= 32'd0;
    end else begin
      r_if_valid <= r_state == ACCESS && r_fetch;
      r_dm_valid <= (r_state == ACCESS && !r_fetch && !w_rmw) || r_state == RMW_WR;
      if (r_state == ACCESS && r_fetch) begin
        r_if_rdata <= r_err ? 32'd0 : w_rd_le;
        r_if_err <= r_err;
      end
      if (r_state == ACCESS && !r_fetch) begin
        r_dm_rdata <= (r_err || r_we) ? 32'd0 : w_load;
        r_dm_err <= r_err;
        r_word <= w_rd_le;
      end
      if (r_state == RMW_WR) begin
        r_dm_rdata <= 32'd0;
        r_dm_err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: scoreboard bench for ram_access_ctrl with a byte-level little-endian reference memory.
module tb_ram_access_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ram_access_ctrl_if bus();
  ram_access_ctrl #(.RAM_ADDR_SIZE(16)) dut (.clock(clk), .reset(rst), .bus(bus));
  typedef struct packed {logic [31:0] rdata; logic err;} exp_t;
  exp_t dm_q[$];
  exp_t if_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  logic [7:0] mem [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic [15:0] w_base;
  assign w_base = {bus.ram_addr[15:2], 2'b00};
  assign bus.ram_data_out = {mem[w_base], mem[w_base + 16'd1], mem[w_base + 16'd2], mem[w_base + 16'd3]};
  always @(posedge clk)
    if (bus.ram_write_control) begin
      mem[w_base] <= bus.ram_data_in[31:24];
      mem[w_base + 16'd1] <= bus.ram_data_in[23:16];
      mem[w_base + 16'd2] <= bus.ram_data_in[15:8];
      mem[w_base + 16'd3] <= bus.ram_data_in[7:0];
      wr_cnt <= wr_cnt + 1;
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (bus.dm_valid) begin
      exp_t e;
      if (dm_q.size() == 0) chk("dm_spurious_valid", 32'd1, 32'd0);
      else begin
        e = dm_q.pop_front();
        chk("dm_rdata", bus.dm_rdata, e.rdata);
        chk("dm_err", 32'(bus.dm_err), 32'(e.err));
      end
    end
  always @(negedge clk)
    if (bus.if_valid) begin
      exp_t e;
      if (if_q.size() == 0) chk("if_spurious_valid", 32'd1, 32'd0);
      else begin
        e = if_q.pop_front();
        chk("if_rdata", bus.if_rdata, e.rdata);
        chk("if_err", 32'(bus.if_err), 32'(e.err));
      end
    end
  always @(negedge clk)
    if (bus.if_gnt && bus.dm_gnt) chk("both_gnt", 32'd1, 32'd0);
  function automatic logic dm_bad(input logic [31:0] a, input logic [1:0] s);
    return s == 2'b11 || (s == 2'b10 && a[1:0] != 2'b00) || (s == 2'b01 && a[0]) || a >= 32'h0001_0000;
  endfunction
  function automatic logic [31:0] ref_word(input logic [15:0] i);
    return {ref_mem[i + 16'd3], ref_mem[i + 16'd2], ref_mem[i + 16'd1], ref_mem[i]};
  endfunction
  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] s, input logic u);
    logic [7:0] b;
    logic [15:0] h;
    b = ref_mem[a[15:0]];
    h = {ref_mem[a[15:0] + 16'd1], ref_mem[a[15:0]]};
    if (s == 2'b00) return u ? {24'd0, b} : {{24{b[7]}}, b};
    if (s == 2'b01) return u ? {16'd0, h} : {{16{h[15]}}, h};
    return ref_word(a[15:0]);
  endfunction
  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    mem[a] <= d;
    ref_mem[a] = d;
  endtask
  task automatic dm_op(input logic we, input logic [31:0] a, input logic [1:0] s, input logic u, input logic [31:0] wd);
    exp_t e;
    logic bad;
    logic got;
    int w0;
    bad = dm_bad(a, s);
    e.err = bad;
    e.rdata = (bad || we) ? 32'd0 : ref_load(a, s, u);
    if (!bad && we)
      for (int k = 0; k < (s == 2'b00 ? 1 : s == 2'b01 ? 2 : 4); k++) ref_mem[a[15:0] + 16'(k)] = wd[8*k +: 8];
    dm_q.push_back(e);
    w0 = wr_cnt;
    @(posedge clk); #1;
    bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = a; bus.dm_size = s; bus.dm_unsigned = u; bus.dm_wdata = wd;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.dm_gnt;
    end
    chk("dm_gnt_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    bus.dm_req = 1'b0;
    if (!bad) begin
      chk("ram_addr", bus.ram_addr, {a[31:2], 2'b11});
      chk("wc_access", 32'(bus.ram_write_control), 32'(we && s == 2'b10));
    end
    for (int i = 0; i < 10 && dm_q.size() != 0; i++) @(negedge clk);
    chk("dm_resp_seen", 32'(dm_q.size()), 32'd0);
    chk("wr_count", 32'(wr_cnt - w0), (we && !bad) ? 32'd1 : 32'd0);
  endtask
  task automatic fetch_op(input logic [31:0] a);
    exp_t e;
    logic got;
    int w0;
    e.err = a[1:0] != 2'b00 || a >= 32'h0001_0000;
    e.rdata = e.err ? 32'd0 : ref_word(a[15:0]);
    if_q.push_back(e);
    w0 = wr_cnt;
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = a;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.if_gnt;
    end
    chk("if_gnt_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    for (int i = 0; i < 10 && if_q.size() != 0; i++) @(negedge clk);
    chk("if_resp_seen", 32'(if_q.size()), 32'd0);
    chk("if_wr_count", 32'(wr_cnt - w0), 32'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int nd, nf, first, w0;
    logic got;
    exp_t e;
    bus.if_req = 1'b0; bus.if_addr = 32'd0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 32'd0; bus.dm_size = 2'b00;
    bus.dm_unsigned = 1'b0; bus.dm_wdata = 32'd0;
    for (int i = 0; i < 65536; i++) poke(16'(i), 8'h00);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_dm_valid", 32'(bus.dm_valid), 32'd0);
    chk("rst_dm_rdata", bus.dm_rdata, 32'd0);
    chk("rst_ram_addr", bus.ram_addr, 32'd0);
    chk("rst_wc", 32'(bus.ram_write_control), 32'd0);
    poke(16'h0100, 8'h11); poke(16'h0101, 8'h22); poke(16'h0102, 8'h33); poke(16'h0103, 8'h44);
    dm_op(1'b0, 32'h100, 2'b10, 1'b0, 32'd0);
    dm_op(1'b0, 32'h103, 2'b00, 1'b0, 32'd0);
    poke(16'h0101, 8'h80);
    dm_op(1'b0, 32'h101, 2'b00, 1'b0, 32'd0);
    dm_op(1'b0, 32'h101, 2'b00, 1'b1, 32'd0);
    poke(16'h0101, 8'h22);
    dm_op(1'b1, 32'h102, 2'b01, 1'b0, 32'h0000_BEEF);
    dm_op(1'b0, 32'h100, 2'b10, 1'b0, 32'd0);
    chk("sh_result", ref_word(16'h0100), 32'hBEEF_2211);
    dm_op(1'b0, 32'h102, 2'b01, 1'b0, 32'd0);
    dm_op(1'b0, 32'h102, 2'b01, 1'b1, 32'd0);
    dm_op(1'b1, 32'h204, 2'b10, 1'b0, 32'hCAFE_BABE);
    dm_op(1'b0, 32'h204, 2'b10, 1'b0, 32'd0);
    dm_op(1'b1, 32'h201, 2'b00, 1'b0, 32'h1234_56A5);
    dm_op(1'b0, 32'h200, 2'b10, 1'b0, 32'd0);
    dm_op(1'b0, 32'h101, 2'b10, 1'b0, 32'd0);
    dm_op(1'b1, 32'h102, 2'b10, 1'b0, 32'hDEAD_DEAD);
    dm_op(1'b0, 32'h101, 2'b01, 1'b0, 32'd0);
    dm_op(1'b0, 32'h100, 2'b11, 1'b0, 32'd0);
    dm_op(1'b1, 32'h1_0000, 2'b10, 1'b0, 32'h5555_5555);
    fetch_op(32'h100);
    fetch_op(32'h102);
    fetch_op(32'h1_0000);
    nd = 0; nf = 0; first = -1;
    @(posedge clk); #1;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h100; bus.dm_size = 2'b10; bus.dm_unsigned = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h204;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.dm_gnt) begin
        e.err = 1'b0; e.rdata = ref_word(16'h0100); dm_q.push_back(e); nd++;
      end
      if (bus.if_gnt) begin
        e.err = 1'b0; e.rdata = ref_word(16'h0204); if_q.push_back(e);
        if (first < 0) first = nd;
        nf++;
      end
    end
    @(posedge clk); #1;
    bus.dm_req = 1'b0; bus.if_req = 1'b0;
`ifdef ARB_FAIRNESS_EN
    chk("arb_first_if_gnt", 32'(first), 32'd4);
    chk("arb_dm_gnts", 32'(nd), 32'd8);
    chk("arb_if_gnts", 32'(nf), 32'd2);
`else
    chk("arb_dm_gnts", 32'(nd), 32'd10);
    chk("arb_if_gnts", 32'(nf), 32'd0);
`endif
    for (int i = 0; i < 10 && (dm_q.size() != 0 || if_q.size() != 0); i++) @(negedge clk);
    chk("arb_drain", 32'(dm_q.size() + if_q.size()), 32'd0);
    poke(16'h0300, 8'h01); poke(16'h0301, 8'h02); poke(16'h0302, 8'h03); poke(16'h0303, 8'h04);
    @(posedge clk); #1;
    w0 = wr_cnt;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h301; bus.dm_size = 2'b00; bus.dm_wdata = 32'h0000_00EE;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.dm_gnt;
    end
    chk("rmw_gnt_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    bus.dm_req = 1'b0;
    chk("rmw_access_wc", 32'(bus.ram_write_control), 32'd0);
    @(posedge clk); #1;
    chk("rmw_wr_wc", 32'(bus.ram_write_control), 32'd1);
    rst = 1'b1;
    #1 chk("rst_forces_wc", 32'(bus.ram_write_control), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_wc", 32'(bus.ram_write_control), 32'd0);
    chk("post_rst_ram_addr", bus.ram_addr, 32'd0);
    chk("post_rst_data_in", bus.ram_data_in, 32'd0);
    chk("post_rst_dm_valid", 32'(bus.dm_valid), 32'd0);
    chk("post_rst_dm_rdata", bus.dm_rdata, 32'd0);
    chk("post_rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("post_rst_if_rdata", bus.if_rdata, 32'd0);
    chk("post_rst_wr_count", 32'(wr_cnt - w0), 32'd0);
    chk("post_rst_mem", {mem[16'h0300], mem[16'h0301], mem[16'h0302], mem[16'h0303]}, 32'h0102_0304);
    dm_op(1'b0, 32'h300, 2'b10, 1'b0, 32'd0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
